// File: rtl/cpu_types_pkg.sv
// Shared CPU types: next-PC select, fetch FSM state
// and the IF/ID pipeline register bundle.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_J   = 2'd2,
    PC_JR  = 2'd3
  } pcsrc_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '0;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: icache side, hazard controls,
// decode feedback and the IF/ID outputs.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        flush;
  pcsrc_t      pc_src;
  logic        halt;
  logic [31:0] rdat1;
  logic [31:0] instr_d;
  logic [31:0] npc_d;
  logic        valid_d;
  logic        halted;

  modport fs (
    input  ihit, iload, stall, flush,
    input  pc_src, halt, rdat1,
    output iREN, iaddr,
    output instr_d, npc_d, valid_d, halted
  );

  modport tb (
    output ihit, iload, stall, flush,
    output pc_src, halt, rdat1,
    input  iREN, iaddr,
    input  instr_d, npc_d, valid_d, halted
  );

endinterface

// File: rtl/pc_target.sv
// Redirect target for the instruction held in IF/ID.
// Only instr[25:0] matters: jump index / branch imm.
module pc_target
  import cpu_types_pkg::*;
(
  input  pcsrc_t      pc_src_i,
  input  logic [31:0] npc_i,
  input  logic [25:0] instr_i,
  input  logic [31:0] rdat1_i,
  output logic [31:0] target_o
);

  logic [31:0] br_off;

  // Sign-extended word offset, then pick target.
  always_comb begin
    br_off   = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    target_o = npc_i;
    unique case (pc_src_i)
      PC_SEQ: target_o = npc_i;
      PC_BR:  target_o = npc_i + br_off;
      PC_J:   target_o = {npc_i[31:28], instr_i, 2'b00};
      PC_JR:  target_o = rdat1_i;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// PC register, icache request and IF/ID register;
// redirects on decoded branch/jump, stops on HALT.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input logic     CLK,
  input logic     RST,
  fetch_stage_if.fs bus
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  ifid_t        ifid_q;
  logic [31:0]  pc_inc;
  logic [31:0]  target;
  logic         redirect;

  pc_target u_tgt (
    .pc_src_i (bus.pc_src),
    .npc_i    (ifid_q.npc),
    .instr_i  (ifid_q.instr[25:0]),
    .rdat1_i  (bus.rdat1),
    .target_o (target)
  );

  assign pc_inc   = pc_q + 32'd4;
  assign redirect = ifid_q.valid
                  && (bus.pc_src != PC_SEQ)
                  && !bus.stall && !bus.halt;

  // Fetch FSM, PC and IF/ID; rule order gives priority.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      ifid_q  <= IFID_BUBBLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.stall) begin
            if (bus.flush) ifid_q <= IFID_BUBBLE;
          end else if (ifid_q.valid && bus.halt) begin
            state_q <= HALTED;
            ifid_q  <= IFID_BUBBLE;
          end else if (redirect) begin
            pc_q   <= target;
            ifid_q <= IFID_BUBBLE;
          end else if (bus.flush) begin
            ifid_q <= IFID_BUBBLE;
            if (bus.ihit) pc_q <= pc_inc;
          end else if (bus.ihit) begin
            pc_q   <= pc_inc;
            ifid_q <= {bus.iload, pc_inc, 1'b1};
          end else begin
            ifid_q <= IFID_BUBBLE;
          end
        end
        HALTED: begin
          ifid_q <= IFID_BUBBLE;
        end
      endcase
    end
  end

  assign bus.iREN    = (state_q == RUN);
  assign bus.iaddr   = pc_q;
  assign bus.instr_d = ifid_q.instr;
  assign bus.npc_d   = ifid_q.npc;
  assign bus.valid_d = ifid_q.valid;
  assign bus.halted  = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus
// halt and reset-during-redirect sequences.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  fetch_stage_if bus ();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        ih;
    logic [31:0] ld;
    logic        st;
    logic        fl;
    logic [1:0]  ps;
    logic        hl;
    logic [31:0] rd;
    logic [31:0] ea;
    logic [31:0] ei;
    logic [31:0] en;
    logic        ev;
    logic        eh;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void add(
    input logic ih, input logic [31:0] ld,
    input logic st, input logic fl,
    input logic [1:0] ps, input logic hl,
    input logic [31:0] rd, input logic [31:0] ea,
    input logic [31:0] ei, input logic [31:0] en,
    input logic ev, input logic eh);
    vec_t v;
    v.ih = ih; v.ld = ld; v.st = st; v.fl = fl;
    v.ps = ps; v.hl = hl; v.rd = rd; v.ea = ea;
    v.ei = ei; v.en = en; v.ev = ev; v.eh = eh;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic [31:0] ld,
                       input logic st, input logic fl,
                       input logic [1:0] ps, input logic hl,
                       input logic [31:0] rd);
    bus.ihit   = ih;
    bus.iload  = ld;
    bus.stall  = st;
    bus.flush  = fl;
    bus.pc_src = pcsrc_t'(ps);
    bus.halt   = hl;
    bus.rdat1  = rd;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // cycle-by-cycle vectors, expectations after the edge
    add(1,32'h3421_0001,0,0,0,0,0, 32'h4,32'h3421_0001,32'h4,1,0);
    add(1,32'h3442_0002,0,0,0,0,0, 32'h8,32'h3442_0002,32'h8,1,0);
    add(0,32'h0,0,0,0,0,0, 32'h8,32'h0,32'h0,0,0);
    add(0,32'h0,0,0,0,0,0, 32'h8,32'h0,32'h0,0,0);
    add(0,32'h0,0,0,0,0,0, 32'h8,32'h0,32'h0,0,0);
    add(1,32'h1000_FFFF,0,0,0,0,0, 32'hC,32'h1000_FFFF,32'hC,1,0);
    add(1,32'hDEAD_BEEF,0,0,1,0,0, 32'h8,32'h0,32'h0,0,0);
    add(1,32'h1000_FFFF,0,0,0,0,0, 32'hC,32'h1000_FFFF,32'hC,1,0);
    add(1,32'h2400_0001,0,0,0,0,0, 32'h10,32'h2400_0001,32'h10,1,0);
    add(1,32'hAAAA_AAAA,0,1,0,0,0, 32'h14,32'h0,32'h0,0,0);
    add(1,32'h2400_0014,0,0,0,0,0, 32'h18,32'h2400_0014,32'h18,1,0);
    add(1,32'hBBBB_BBBB,1,1,0,0,0, 32'h18,32'h0,32'h0,0,0);
    add(1,32'h0000_0008,0,0,0,0,0, 32'h1C,32'h8,32'h1C,1,0);
    add(1,32'hCCCC_CCCC,1,0,3,0,32'h200, 32'h1C,32'h8,32'h1C,1,0);
    add(1,32'hCCCC_CCCC,1,0,3,0,32'h200, 32'h1C,32'h8,32'h1C,1,0);
    add(1,32'hCCCC_CCCC,0,0,3,0,32'h200, 32'h200,32'h0,32'h0,0,0);
    add(0,32'h0,0,0,3,0,32'h999, 32'h200,32'h0,32'h0,0,0);
    add(1,32'h0000_0008,0,0,0,0,0, 32'h204,32'h8,32'h204,1,0);
    add(1,32'hDDDD_DDDD,0,0,3,0,32'h4000_0000,
        32'h4000_0000,32'h0,32'h0,0,0);
    add(1,32'h0800_0040,0,0,0,0,0,
        32'h4000_0004,32'h0800_0040,32'h4000_0004,1,0);
    add(1,32'hEEEE_EEEE,0,0,2,0,0, 32'h4000_0100,32'h0,32'h0,0,0);
    add(1,32'h0000_0008,0,0,0,0,0,
        32'h4000_0104,32'h8,32'h4000_0104,1,0);
    add(1,32'hEEEE_EEEE,0,0,3,0,32'hFFFF_FFFC,
        32'hFFFF_FFFC,32'h0,32'h0,0,0);
    add(1,32'h1000_FFFF,0,0,0,0,0, 32'h0,32'h1000_FFFF,32'h0,1,0);
    add(1,32'hEEEE_EEEE,0,0,1,0,0, 32'hFFFF_FFFC,32'h0,32'h0,0,0);
    add(1,32'h0000_000C,0,0,0,1,0, 32'h0,32'hC,32'h0,1,0);
    add(1,32'hEEEE_EEEE,1,0,0,1,0, 32'h0,32'hC,32'h0,1,0);
    add(1,32'hEEEE_EEEE,0,0,1,1,0, 32'h0,32'h0,32'h0,0,1);

    drive(0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    #3;
    chk("rst.iaddr",   bus.iaddr,   32'h0);
    chk("rst.iREN",    32'(bus.iREN), 32'd1);
    chk("rst.instr_d", bus.instr_d, 32'h0);
    chk("rst.npc_d",   bus.npc_d,   32'h0);
    chk("rst.valid_d", 32'(bus.valid_d), 32'd0);
    chk("rst.halted",  32'(bus.halted),  32'd0);
    step();
    RST = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].ih, vq[i].ld, vq[i].st, vq[i].fl,
            vq[i].ps, vq[i].hl, vq[i].rd);
      step();
      chk($sformatf("v%0d.iaddr", i), bus.iaddr, vq[i].ea);
      chk($sformatf("v%0d.instr_d", i), bus.instr_d, vq[i].ei);
      chk($sformatf("v%0d.npc_d", i), bus.npc_d, vq[i].en);
      chk($sformatf("v%0d.valid_d", i),
          32'(bus.valid_d), 32'(vq[i].ev));
      chk($sformatf("v%0d.halted", i),
          32'(bus.halted), 32'(vq[i].eh));
      chk($sformatf("v%0d.iREN", i),
          32'(bus.iREN), 32'(!vq[i].eh));
    end

    // halted: nothing moves whatever the inputs do
    for (int c = 0; c < 20; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom,
            1'b0, 1'($urandom_range(0, 1)),
            2'd3, 1'($urandom_range(0, 1)), 32'h123);
      step();
      chk($sformatf("hlt%0d.iaddr", c), bus.iaddr, 32'h0);
      chk($sformatf("hlt%0d.state", c),
          {29'd0, bus.iREN, bus.halted, bus.valid_d},
          32'b010);
    end

    // async reset out of HALTED, mid-cycle
    #2;
    RST = 1'b1;
    #1;
    chk("hrst.iREN",   32'(bus.iREN),   32'd1);
    chk("hrst.halted", 32'(bus.halted), 32'd0);
    chk("hrst.iaddr",  bus.iaddr,       32'h0);
    step();
    RST = 1'b0;

    // reset while a stalled JR is pending
    drive(1, 32'h0000_0008, 0, 0, 0, 0, 0);
    step();
    chk("jrr.fetch", bus.npc_d, 32'h4);
    drive(1, 32'hEEEE_EEEE, 1, 0, 3, 0, 32'h300);
    step();
    chk("jrr.hold", bus.iaddr, 32'h4);
    drive(1, 32'hEEEE_EEEE, 0, 0, 3, 0, 32'h500);
    #1;
    chk("jrr.nocomb", bus.iaddr, 32'h4);
    RST = 1'b1;
    #1;
    chk("jrr.rst.iaddr", bus.iaddr, 32'h0);
    chk("jrr.rst.valid", 32'(bus.valid_d), 32'd0);
    step();
    RST = 1'b0;
    drive(0, 32'h0, 0, 0, 3, 0, 32'h300);
    step();
    chk("jrr.gone", bus.iaddr, 32'h0);
    drive(1, 32'h2400_0001, 0, 0, 0, 0, 0);
    step();
    chk("jrr.resume", bus.iaddr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
